memory_window_fetch: RTL and testbench
======================================

Name: memory_window_fetch

Overview:
- Parametrised successor of the single/triple-value memory controller.
- Fetches a run of 1..MAX_COUNT consecutive elements from a row-major 2D image or kernel memory, starting at a {row,col} index. The run is either horizontal (along a row) or vertical (down a column).
- Pipelines one read per cycle against a memory with MEM_LATENCY cycles of read latency, zero-pads out-of-bounds elements, and returns all elements packed on one bus with a one-cycle HANDSHAKE.
- Sits between the pipelined CPU's vector load path and the kernel/picture memories.

Parameters:
DATA_W, 16, element width in bits
IDX_W, 16, width of each row/col index field
ADDR_W, 32, memory address width
MAX_COUNT, 3, maximum elements per fetch
MEM_LATENCY, 1, cycles from MemRe/MemAddr to valid MemData (≥1)
SIGN_EXT, 1, 1: READ_SCALAR is the sign-extended element 0; 0: zero-extended

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
START  in  1  request pulse; sampled only in IDLE
MODE  in  1  0 = horizontal (col+k), 1 = vertical (row+k)
COUNT  in  CW  elements requested, CW = $clog2(MAX_COUNT+1)
INDEX  in  2*IDX_W  {row, col} of element 0
BASE_ADDR  in  ADDR_W  address of element (0,0)
IMG_WIDTH  in  IDX_W  columns in image (row stride)
IMG_HEIGHT  in  IDX_W  rows in image
MemAddr  out  ADDR_W  memory read address
MemRe  out  1  memory read enable
MemData  in  DATA_W  memory read data
READ  out  MAX_COUNT*DATA_W  element k in bits [k*DATA_W +: DATA_W]
READ_SCALAR  out  ADDR_W  element 0 extended per SIGN_EXT
HANDSHAKE  out  1  one-cycle result valid
BUSY  out  1  high from accepted START until HANDSHAKE cycle inclusive
OOB  out  1  valid with HANDSHAKE: ≥1 element was out of bounds

Behaviour:
- Reset (RESET low, asynchronous): state IDLE.
  - MemAddr = 0, MemRe = 0, READ = 0, READ_SCALAR = 0, HANDSHAKE = 0, BUSY = 0, OOB = 0.
  - Internal issue/return counters and the valid-tag pipeline are cleared.
  - Asserting reset mid-fetch aborts the fetch. No HANDSHAKE is produced. Late-returning MemData is ignored.
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE: on START=1 at edge t0:
  - Latch INDEX, MODE, BASE_ADDR, IMG_WIDTH, IMG_HEIGHT.
  - Latch N = COUNT clamped to [1, MAX_COUNT]: COUNT=0 → N=1; COUNT>MAX_COUNT → N=MAX_COUNT.
  - Clear READ slots to 0. Go to ISSUE.
- ISSUE: lasts exactly N cycles (t0+1 .. t0+N), with k = 0..N-1.
  - Element k: r = row + k·MODE, c = col + k·(1-MODE).
  - In-bounds when r < IMG_HEIGHT and c < IMG_WIDTH. Comparisons are unsigned. Index arithmetic is IDX_W+1 bits, so wrap counts as out-of-bounds.
  - In-bounds: MemRe = 1 and MemAddr = BASE_ADDR + r·IMG_WIDTH + c, truncated to ADDR_W.
  - Out-of-bounds: MemRe = 0, MemAddr holds its last value, the slot stays 0, and sticky OOB is set.
  - A {valid, slot, inbounds} tag enters a MEM_LATENCY-deep shift pipeline each ISSUE cycle.
- DRAIN: while the tag pipeline is non-empty, MemRe = 0.
  - A tag exiting with inbounds=1 captures MemData into READ slot k.
  - Leave DRAIN the cycle after the last tag exits.
- DONE: HANDSHAKE = 1 for exactly one cycle, t0+N+MEM_LATENCY+1. READ_SCALAR is driven from slot 0.
- After DONE, READ and READ_SCALAR hold until the next accepted START. OOB holds until the next accepted START.
- START while BUSY is ignored. It is not queued.
- Slots ≥ N read as 0.
- A START in the same cycle as HANDSHAKE is ignored. The earliest accepted START is the cycle after HANDSHAKE.

Test Plan:
- Single value: reset; IMG 8×8, BASE 0x100, INDEX {2,3}, COUNT=1, MEM_LATENCY=1, mem[i]=i, START at t0:
  - MemAddr 0x113 at t0+1.
  - HANDSHAKE at t0+3.
  - READ[15:0] = 0x0113, READ_SCALAR = 0x00000113, OOB = 0.
- Horizontal ×3 in-bounds: INDEX {2,3}, MODE=0, COUNT=3:
  - MemAddr 0x113, 0x114, 0x115 on consecutive cycles.
  - HANDSHAKE at t0+5.
  - READ = {0x0115, 0x0114, 0x0113}.
- Vertical with bottom padding: INDEX {6,1}, MODE=1, COUNT=3, IMG_HEIGHT 8:
  - Addresses 0x131, 0x139; third cycle MemRe = 0.
  - READ = {0x0000, 0x0139, 0x0131}, OOB = 1.
- Latency and clamping: MEM_LATENCY=3, COUNT=7 clamped to 3, horizontal from {0,0}:
  - HANDSHAKE at t0+7, all three slots correct.
- Sign extension: mem value 0x8001, COUNT=1, SIGN_EXT=1 → READ_SCALAR = 0xFFFF8001.
- Abort and busy:
  - RESET low at t0+2 of a 3-element fetch → all outputs 0 immediately, no HANDSHAKE.
  - After release, a START while BUSY is ignored: exactly one HANDSHAKE per accepted START.

Source files
------------

// File: rtl/memory_window_fetch.sv
// Fetches a horizontal or vertical run of up to MAX_COUNT elements from a row-major
// image memory, zero-padding out-of-bounds elements, and returns them packed on READ.
module memory_window_fetch #(
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 16,
  parameter int ADDR_W      = 32,
  parameter int MAX_COUNT   = 3,
  parameter int MEM_LATENCY = 1,
  parameter int SIGN_EXT    = 1
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic                                 START,
  input  logic                                 MODE,
  input  logic [$clog2(MAX_COUNT+1)-1:0]       COUNT,
  input  logic [2*IDX_W-1:0]                   INDEX,
  input  logic [ADDR_W-1:0]                    BASE_ADDR,
  input  logic [IDX_W-1:0]                     IMG_WIDTH,
  input  logic [IDX_W-1:0]                     IMG_HEIGHT,
  output logic [ADDR_W-1:0]                    MemAddr,
  output logic                                 MemRe,
  input  logic [DATA_W-1:0]                    MemData,
  output logic [MAX_COUNT*DATA_W-1:0]          READ,
  output logic [ADDR_W-1:0]                    READ_SCALAR,
  output logic                                 HANDSHAKE,
  output logic                                 BUSY,
  output logic                                 OOB
);
  localparam int CW = $clog2(MAX_COUNT+1);
  localparam int MW = 2*IDX_W+2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    row_reg, col_reg, width_reg, height_reg;
  logic                mode_reg;
  logic [ADDR_W-1:0]   base_reg;
  logic [CW-1:0]       n_reg, k_reg, n_next;

  // Stage 0 is aligned with the issued MemAddr; stage MEM_LATENCY lines up with MemData.
  logic [MEM_LATENCY:0] tag_valid_reg, tag_inb_reg;
  logic [CW-1:0]        tag_slot_reg [MEM_LATENCY+1];

  logic [IDX_W:0]       k_ext, r_ext, c_ext;
  logic                 elem_inb;
  logic [ADDR_W-1:0]    elem_addr;
  logic                 exit_valid, capture, last_exit;
  logic [CW-1:0]        exit_slot;
  logic [DATA_W-1:0]    slot0_next;
  logic [ADDR_W-1:0]    scalar_next;

  always_comb begin
    n_next = COUNT;
    if (COUNT == '0)
      n_next = CW'(1);
    else if (COUNT > CW'(MAX_COUNT))
      n_next = CW'(MAX_COUNT);
  end

  // One extra index bit so that row/col overflow lands out of bounds instead of wrapping.
  always_comb begin
    k_ext     = (IDX_W+1)'(k_reg);
    r_ext     = {1'b0, row_reg} + (mode_reg ? k_ext : '0);
    c_ext     = {1'b0, col_reg} + (mode_reg ? '0 : k_ext);
    elem_inb  = (r_ext < {1'b0, height_reg}) && (c_ext < {1'b0, width_reg});
    elem_addr = base_reg + ADDR_W'(MW'(r_ext) * MW'(width_reg)) + ADDR_W'(c_ext);
  end

  assign exit_valid = tag_valid_reg[MEM_LATENCY];
  assign exit_slot  = tag_slot_reg[MEM_LATENCY];
  assign capture    = exit_valid && tag_inb_reg[MEM_LATENCY];
  assign last_exit  = exit_valid && (exit_slot == n_reg - 1'b1);

  always_comb begin
    slot0_next = READ[DATA_W-1:0];
    if (capture && exit_slot == '0)
      slot0_next = MemData;
    scalar_next = {ADDR_W{(SIGN_EXT != 0) && slot0_next[DATA_W-1]}};
    scalar_next[DATA_W-1:0] = slot0_next;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      width_reg     <= '0;
      height_reg    <= '0;
      mode_reg      <= 1'b0;
      base_reg      <= '0;
      n_reg         <= '0;
      k_reg         <= '0;
      tag_valid_reg <= '0;
      tag_inb_reg   <= '0;
      for (int s = 0; s <= MEM_LATENCY; s++)
        tag_slot_reg[s] <= '0;
      MemAddr       <= '0;
      MemRe         <= 1'b0;
      READ          <= '0;
      READ_SCALAR   <= '0;
      HANDSHAKE     <= 1'b0;
      BUSY          <= 1'b0;
      OOB           <= 1'b0;
    end else begin
      HANDSHAKE        <= 1'b0;
      MemRe            <= 1'b0;
      tag_valid_reg[0] <= 1'b0;
      for (int s = 1; s <= MEM_LATENCY; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_inb_reg[s]   <= tag_inb_reg[s-1];
        tag_slot_reg[s]  <= tag_slot_reg[s-1];
      end
      if (capture) begin
        for (int s = 0; s < MAX_COUNT; s++)
          if (exit_slot == CW'(s))
            READ[s*DATA_W +: DATA_W] <= MemData;
      end

      case (state_reg)
        IDLE: begin
          if (START) begin
            row_reg    <= INDEX[2*IDX_W-1:IDX_W];
            col_reg    <= INDEX[IDX_W-1:0];
            mode_reg   <= MODE;
            base_reg   <= BASE_ADDR;
            width_reg  <= IMG_WIDTH;
            height_reg <= IMG_HEIGHT;
            n_reg      <= n_next;
            k_reg      <= '0;
            READ       <= '0;
            OOB        <= 1'b0;
            BUSY       <= 1'b1;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          tag_valid_reg[0] <= 1'b1;
          tag_inb_reg[0]   <= elem_inb;
          tag_slot_reg[0]  <= k_reg;
          if (elem_inb) begin
            MemRe   <= 1'b1;
            MemAddr <= elem_addr;
          end else begin
            OOB <= 1'b1;
          end
          k_reg <= k_reg + 1'b1;
          if (k_reg == n_reg - 1'b1)
            state_reg <= DRAIN;
        end
        DRAIN: begin
          if (last_exit) begin
            HANDSHAKE   <= 1'b1;
            READ_SCALAR <= scalar_next;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          BUSY      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_window_fetch.sv
// Directed bench for memory_window_fetch: one instance at latency 1 / MAX_COUNT 3 and one
// at latency 3 / MAX_COUNT 5, each with a memory model returning the low address bits.
module tb_memory_window_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start1, start3, mode;
  logic [1:0]  cnt1;
  logic [2:0]  cnt3;
  logic [31:0] index, base;
  logic [15:0] img_w, img_h;

  logic [31:0] u1_addr, u3_addr, u1_sc, u3_sc;
  logic        u1_re, u3_re, u1_hs, u3_hs, u1_busy, u3_busy, u1_oob, u3_oob;
  logic [15:0] u1_data, u3_data;
  logic [47:0] u1_read;
  logic [79:0] u3_read;

  memory_window_fetch u1 (
    .CLK(clk), .RESET(rst_n), .START(start1), .MODE(mode), .COUNT(cnt1), .INDEX(index),
    .BASE_ADDR(base), .IMG_WIDTH(img_w), .IMG_HEIGHT(img_h), .MemAddr(u1_addr), .MemRe(u1_re),
    .MemData(u1_data), .READ(u1_read), .READ_SCALAR(u1_sc), .HANDSHAKE(u1_hs), .BUSY(u1_busy),
    .OOB(u1_oob));

  memory_window_fetch #(.MAX_COUNT(5), .MEM_LATENCY(3)) u3 (
    .CLK(clk), .RESET(rst_n), .START(start3), .MODE(mode), .COUNT(cnt3), .INDEX(index),
    .BASE_ADDR(base), .IMG_WIDTH(img_w), .IMG_HEIGHT(img_h), .MemAddr(u3_addr), .MemRe(u3_re),
    .MemData(u3_data), .READ(u3_read), .READ_SCALAR(u3_sc), .HANDSHAKE(u3_hs), .BUSY(u3_busy),
    .OOB(u3_oob));

  // Memory models: mem[a] = a[15:0]; reads without MemRe return a poison value.
  logic [15:0] m1_p;
  logic [15:0] m3_p [3];
  always @(posedge clk) begin
    m1_p    <= u1_re ? u1_addr[15:0] : 16'hDEAD;
    m3_p[0] <= u3_re ? u3_addr[15:0] : 16'hDEAD;
    m3_p[1] <= m3_p[0];
    m3_p[2] <= m3_p[1];
  end
  assign u1_data = m1_p;
  assign u3_data = m3_p[2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    bit               sel;
    bit               mode;
    logic [2:0]       count;
    logic [15:0]      row, col;
    logic [31:0]      base;
    logic [15:0]      w, h;
    int               lat;
    logic [4:0]       re;
    logic [4:0][31:0] addr;
    logic [79:0]      rd;
    logic [31:0]      sc;
    bit               oob;
  } vec_t;

  function automatic vec_t mk(bit sel, bit md, int count, int row, int col, int b, int w, int h,
                              int lat, logic [4:0] re, logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] a2, logic [31:0] a3, logic [31:0] a4,
                              logic [79:0] rd, logic [31:0] sc, bit oob);
    vec_t v;
    v.sel = sel; v.mode = md; v.count = count[2:0];
    v.row = row[15:0]; v.col = col[15:0]; v.base = b;
    v.w = w[15:0]; v.h = h[15:0]; v.lat = lat; v.re = re;
    v.addr = {a4, a3, a2, a1, a0};
    v.rd = rd; v.sc = sc; v.oob = oob;
    return v;
  endfunction

  vec_t vecs[12];

  task automatic run_vec(input int idx, input vec_t v);
    logic [4:0]       re_seen;
    logic [4:0][31:0] addr_seen;
    int               hs_cyc, hs_cnt;
    bit               re_extra, busy1;
    logic [79:0]      got_read;
    logic [31:0]      got_sc, cur_addr;
    logic             got_oob, cur_re, cur_hs;
    re_seen = '0; addr_seen = '0; hs_cyc = -1; hs_cnt = 0; re_extra = 0; busy1 = 0;
    got_read = '0; got_sc = '0; got_oob = 1'b0;
    @(negedge clk);
    mode = v.mode; index = {v.row, v.col}; base = v.base; img_w = v.w; img_h = v.h;
    cnt1 = v.count[1:0]; cnt3 = v.count;
    if (v.sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      cur_re   = v.sel ? u3_re : u1_re;
      cur_hs   = v.sel ? u3_hs : u1_hs;
      cur_addr = v.sel ? u3_addr : u1_addr;
      if (c == 1) busy1 = v.sel ? u3_busy : u1_busy;
      if (cur_re) begin
        if (c <= 5) begin
          re_seen[c-1] = 1'b1;
          addr_seen[c-1] = cur_addr;
        end else begin
          re_extra = 1'b1;
        end
      end
      if (cur_hs) begin
        hs_cnt++;
        if (hs_cyc < 0) begin
          hs_cyc   = c;
          got_read = v.sel ? u3_read : {32'b0, u1_read};
          got_sc   = v.sel ? u3_sc : u1_sc;
          got_oob  = v.sel ? u3_oob : u1_oob;
        end
      end
    end
    $display("vec %0d: sel=%0d hs_cycle=%0d read=%h scalar=%h oob=%0b", idx, v.sel, hs_cyc,
             got_read, got_sc, got_oob);
    check($sformatf("v%0d_busy", idx), 80'(busy1), 80'd1);
    check($sformatf("v%0d_hs_cycle", idx), 80'(hs_cyc), 80'(v.lat));
    check($sformatf("v%0d_hs_count", idx), 80'(hs_cnt), 80'd1);
    check($sformatf("v%0d_re_pattern", idx), 80'(re_seen), 80'(v.re));
    check($sformatf("v%0d_re_late", idx), 80'(re_extra), 80'd0);
    for (int i = 0; i < 5; i++)
      if (v.re[i]) check($sformatf("v%0d_addr%0d", idx, i), 80'(addr_seen[i]), 80'(v.addr[i]));
    check($sformatf("v%0d_read", idx), got_read, v.rd);
    check($sformatf("v%0d_scalar", idx), 80'(got_sc), 80'(v.sc));
    check($sformatf("v%0d_oob", idx), 80'(got_oob), 80'(v.oob));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt, re_cnt, hs_cyc;
    logic [79:0] got_read;

    //      sel md cnt row col    base     w       h    lat re        a0          a1          a2          a3          a4
    vecs[0]  = mk(0, 0, 1, 2, 3,      32'h100, 8,      8, 3, 5'b00001, 32'h113,    0,          0,          0, 0,
                  80'h0113, 32'h113, 0);
    vecs[1]  = mk(0, 0, 3, 2, 3,      32'h100, 8,      8, 5, 5'b00111, 32'h113,    32'h114,    32'h115,    0, 0,
                  80'h0115_0114_0113, 32'h113, 0);
    vecs[2]  = mk(0, 1, 3, 6, 1,      32'h100, 8,      8, 5, 5'b00011, 32'h131,    32'h139,    0,          0, 0,
                  80'h0000_0139_0131, 32'h131, 1);
    vecs[3]  = mk(0, 0, 0, 7, 7,      32'h100, 8,      8, 3, 5'b00001, 32'h13F,    0,          0,          0, 0,
                  80'h013F, 32'h13F, 0);
    vecs[4]  = mk(0, 0, 3, 0, 6,      32'h100, 8,      8, 5, 5'b00011, 32'h106,    32'h107,    0,          0, 0,
                  80'h0000_0107_0106, 32'h106, 1);
    vecs[5]  = mk(0, 0, 2, 1, 0,      32'h100, 8,      8, 4, 5'b00011, 32'h108,    32'h109,    0,          0, 0,
                  80'h0109_0108, 32'h108, 0);
    vecs[6]  = mk(0, 0, 1, 0, 0,      32'h8001, 8,     8, 3, 5'b00001, 32'h8001,   0,          0,          0, 0,
                  80'h8001, 32'hFFFF8001, 0);
    vecs[7]  = mk(0, 0, 2, 8, 0,      32'h100, 8,      8, 4, 5'b00000, 0,          0,          0,          0, 0,
                  80'h0, 32'h0, 1);
    vecs[8]  = mk(0, 0, 3, 0, 'hFFFE, 32'h0,   'hFFFF, 1, 5, 5'b00001, 32'hFFFE,   0,          0,          0, 0,
                  80'hFFFE, 32'hFFFFFFFE, 1);
    vecs[9]  = mk(1, 0, 7, 0, 0,      32'h100, 8,      8, 9, 5'b11111, 32'h100,    32'h101,    32'h102,    32'h103, 32'h104,
                  80'h0104_0103_0102_0101_0100, 32'h100, 0);
    vecs[10] = mk(1, 1, 2, 7, 2,      32'h100, 8,      8, 6, 5'b00001, 32'h13A,    0,          0,          0, 0,
                  80'h013A, 32'h13A, 1);
    vecs[11] = mk(0, 1, 3, 0, 5,      32'h200, 8,      8, 5, 5'b00111, 32'h205,    32'h20D,    32'h215,    0, 0,
                  80'h0215_020D_0205, 32'h205, 0);

    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 1'b0; cnt1 = '0; cnt3 = '0;
    index = '0; base = '0; img_w = '0; img_h = '0;
    repeat (3) @(negedge clk);
    check("rst_u1_addr", 80'(u1_addr), 80'd0);
    check("rst_u1_re", 80'(u1_re), 80'd0);
    check("rst_u1_read", 80'(u1_read), 80'd0);
    check("rst_u1_scalar", 80'(u1_sc), 80'd0);
    check("rst_u1_hs", 80'(u1_hs), 80'd0);
    check("rst_u1_busy", 80'(u1_busy), 80'd0);
    check("rst_u1_oob", 80'(u1_oob), 80'd0);
    check("rst_u3_read", u3_read, 80'd0);
    check("rst_u3_busy", 80'(u3_busy), 80'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_vec(i, vecs[i]);

    // Reset asserted two cycles into a 3-element fetch must clear everything at once.
    @(negedge clk);
    mode = 1'b0; index = {16'd2, 16'd3}; base = 32'h100; img_w = 16'd8; img_h = 16'd8;
    cnt1 = 2'd3; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_pre_busy", 80'(u1_busy), 80'd1);
    check("abort_pre_addr", 80'(u1_addr), 80'h114);
    rst_n = 1'b0;
    #1;
    check("abort_addr", 80'(u1_addr), 80'd0);
    check("abort_re", 80'(u1_re), 80'd0);
    check("abort_read", 80'(u1_read), 80'd0);
    check("abort_scalar", 80'(u1_sc), 80'd0);
    check("abort_busy", 80'(u1_busy), 80'd0);
    check("abort_hs", 80'(u1_hs), 80'd0);
    check("abort_oob", 80'(u1_oob), 80'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    hs_cnt = 0; re_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (u1_hs) hs_cnt++;
      if (u1_re) re_cnt++;
    end
    $display("abort: handshakes after release=%0d reads=%0d", hs_cnt, re_cnt);
    check("abort_no_hs", 80'(hs_cnt), 80'd0);
    check("abort_no_re", 80'(re_cnt), 80'd0);

    // START while busy and START coinciding with HANDSHAKE are both dropped.
    @(negedge clk);
    mode = 1'b0; index = {16'd2, 16'd3}; base = 32'h100; img_w = 16'd8; img_h = 16'd8;
    cnt1 = 2'd3; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    index = {16'd0, 16'd0};
    hs_cnt = 0; re_cnt = 0; hs_cyc = -1; got_read = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (u1_re) re_cnt++;
      if (u1_hs) begin
        hs_cnt++;
        if (hs_cyc < 0) begin
          hs_cyc = c;
          got_read = {32'b0, u1_read};
        end
      end
      @(negedge clk);
      start1 = (c == 2) || (c == hs_cyc);
    end
    $display("busy: handshakes=%0d first=%0d reads=%0d read=%h", hs_cnt, hs_cyc, re_cnt, got_read);
    check("busy_hs_count", 80'(hs_cnt), 80'd1);
    check("busy_hs_cycle", 80'(hs_cyc), 80'd5);
    check("busy_re_count", 80'(re_cnt), 80'd3);
    check("busy_read", got_read, 80'h0115_0114_0113);
    check("busy_idle_after", 80'(u1_busy), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
